avalon_pio_irq: RTL and testbench

//   Parametrised Avalon-MM GPIO peripheral replacing the fixed-width key/switch/LED PIOs in nios2_system.

---
 rtl/avalon_pio_irq.sv | 213 +++++++++++++++++++++
 tb/tb_avalon_pio_irq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_pio_irq
//  Purpose  : Parametrised Avalon-MM GPIO peripheral. The input channel runs
//             raw pins through a synchroniser, a per-bit tick-sampled
//             debouncer and an edge detector. Captured edges are masked into
//             a registered level interrupt. The output channel is a register
//             with atomic set/clear write addresses.
//  Ports    : clk_clk         in   1          system clock
//             reset_reset_n   in   1          asynchronous active-low reset
//             avs_address     in   3          word address
//             avs_read        in   1          read strobe
//             avs_write       in   1          write strobe
//             avs_writedata   in   32         write data
//             avs_readdata    out  32         read data, 1-clock latency, held
//             pio_in_export   in   IN_WIDTH   raw asynchronous inputs
//             pio_out_export  out  OUT_WIDTH  output register
//             irq             out  1          level interrupt, active high
//  Register map (word addresses):
//             0 DATA   R  debounced inputs
//             1 OUT    RW output register
//             2 MASK   RW irq mask
//             3 EDGE   R  captured edges, W1C
//             4 OUTSET W  OUT |= wdata (reads 0)
//             5 OUTCLR W  OUT &= ~wdata (reads 0)
//             6-7      reserved, read 0
//  Revision : 1.0  initial release
// ============================================================================
module avalon_pio_irq #(
   parameter int IN_WIDTH         = 18,
   parameter int OUT_WIDTH        = 18,
   parameter int SYNC_STAGES      = 2,
   parameter int DEBOUNCE_CYCLES  = 50000,
   parameter int DEBOUNCE_SAMPLES = 3,
   parameter int EDGE_MODE        = 0,
   parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic [2:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   input  logic [IN_WIDTH-1:0]  pio_in_export,
   output logic [OUT_WIDTH-1:0] pio_out_export,
   output logic                 irq
);

   localparam int                 c_pre_w      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_pre_w-1:0] c_pre_max    = c_pre_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_pre_w-1:0] c_pre_one    = c_pre_w'(1);
   localparam logic [3:0]         c_samples_m1 = 4'(DEBOUNCE_SAMPLES - 1);

   localparam logic [2:0] c_addr_data   = 3'd0;
   localparam logic [2:0] c_addr_out    = 3'd1;
   localparam logic [2:0] c_addr_mask   = 3'd2;
   localparam logic [2:0] c_addr_edge   = 3'd3;
   localparam logic [2:0] c_addr_outset = 3'd4;
   localparam logic [2:0] c_addr_outclr = 3'd5;

   logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] r_sync;
   logic [IN_WIDTH-1:0]                  w_sync;
   logic [c_pre_w-1:0]                   r_pre;
   logic                                 w_tick;
   logic [IN_WIDTH-1:0][3:0]             r_cnt;
   logic [IN_WIDTH-1:0]                  r_deb;
   logic [IN_WIDTH-1:0]                  r_deb_d;
   logic [IN_WIDTH-1:0]                  w_det;
   logic [IN_WIDTH-1:0]                  r_edge;
   logic [IN_WIDTH-1:0]                  r_mask;
   logic [OUT_WIDTH-1:0]                 r_out;
   logic                                 r_irq;
   logic [31:0]                          r_rdata;
   logic [31:0]                          w_rdata;
   logic [IN_WIDTH-1:0]                  w_wdata_in;
   logic [OUT_WIDTH-1:0]                 w_wdata_out;
   logic [IN_WIDTH-1:0]                  w_edge_clr;
   logic                                 w_unused_wdata;

   assign w_wdata_in     = avs_writedata[IN_WIDTH-1:0];
   assign w_wdata_out    = avs_writedata[OUT_WIDTH-1:0];
   // High write-data bits beyond the register widths are intentionally dropped.
   assign w_unused_wdata = &{1'b0, avs_writedata};

   // ------------------------------------------------------------------------
   // Input synchroniser: shift the raw pins through SYNC_STAGES flops.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pio_in_export};
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // Debounce prescaler: one-clock tick each time it wraps.
   // ------------------------------------------------------------------------
   assign w_tick = (r_pre == c_pre_max);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + c_pre_one;
      end
   end

   // ------------------------------------------------------------------------
   // Per-bit debouncer: a new level is accepted only after DEBOUNCE_SAMPLES
   // consecutive ticks that all disagree with the current debounced value.
   // Any agreeing tick restarts the count.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_cnt <= '0;
         r_deb <= '0;
      end else if (w_tick) begin
         for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_sync[i] != r_deb[i]) begin
               if (r_cnt[i] == c_samples_m1) begin
                  r_deb[i] <= w_sync[i];
                  r_cnt[i] <= 4'd0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 4'd1;
               end
            end else begin
               r_cnt[i] <= 4'd0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Edge detection on the debounced value.
   // ------------------------------------------------------------------------
   generate
      if (EDGE_MODE == 0) begin : g_rise
         assign w_det = r_deb & ~r_deb_d;
      end else if (EDGE_MODE == 1) begin : g_fall
         assign w_det = ~r_deb & r_deb_d;
      end else begin : g_any
         assign w_det = r_deb ^ r_deb_d;
      end
   endgenerate

   assign w_edge_clr = (avs_write && (avs_address == c_addr_edge)) ? w_wdata_in : '0;

   // Clear is applied first so that a same-cycle detected edge wins.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_deb_d <= '0;
         r_edge  <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_deb_d <= r_deb;
         r_edge  <= (r_edge & ~w_edge_clr) | w_det;
         r_irq   <= |(r_edge & r_mask);
      end
   end

   // ------------------------------------------------------------------------
   // Writable registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_out  <= OUT_RESET;
         r_mask <= '0;
      end else if (avs_write) begin
         case (avs_address)
            c_addr_out:    r_out  <= w_wdata_out;
            c_addr_mask:   r_mask <= w_wdata_in;
            c_addr_outset: r_out  <= r_out | w_wdata_out;
            c_addr_outclr: r_out  <= r_out & ~w_wdata_out;
            default:       ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Read path: the mux sees pre-write register values, so a simultaneous
   // read and write returns the old contents.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      case (avs_address)
         c_addr_data: w_rdata[IN_WIDTH-1:0]  = r_deb;
         c_addr_out:  w_rdata[OUT_WIDTH-1:0] = r_out;
         c_addr_mask: w_rdata[IN_WIDTH-1:0]  = r_mask;
         c_addr_edge: w_rdata[IN_WIDTH-1:0]  = r_edge;
         default:     ;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_rdata <= '0;
      end else if (avs_read) begin
         r_rdata <= w_rdata;
      end
   end

   assign avs_readdata   = r_rdata;
   assign pio_out_export = r_out;
   assign irq            = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avalon_pio_irq
//  Purpose  : Directed self-checking bench for avalon_pio_irq. Instance A is
//             18/18 bits, 4-clock prescaler, 3 samples, any-edge, OUT reset
//             0x0A5. Instance B is 3/9 bits, tick every clock, 1 sample,
//             rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_avalon_pio_irq;

   logic        clk;
   logic        rst_n;

   logic [2:0]  a_addr;
   logic        a_rd;
   logic        a_wr;
   logic [31:0] a_wd;
   logic [31:0] a_rdata;
   logic [17:0] a_in;
   logic [17:0] a_out;
   logic        a_irq;

   logic [2:0]  b_addr;
   logic        b_rd;
   logic        b_wr;
   logic [31:0] b_wd;
   logic [31:0] b_rdata;
   logic [2:0]  b_in;
   logic [8:0]  b_out;
   logic        b_irq;

   int total;
   int bad;

   avalon_pio_irq #(
      .IN_WIDTH(18), .OUT_WIDTH(18), .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4), .DEBOUNCE_SAMPLES(3), .EDGE_MODE(2),
      .OUT_RESET(18'h000A5)
   ) u_dut_a (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .avs_address(a_addr), .avs_read(a_rd), .avs_write(a_wr),
      .avs_writedata(a_wd), .avs_readdata(a_rdata),
      .pio_in_export(a_in), .pio_out_export(a_out), .irq(a_irq)
   );

   avalon_pio_irq #(
      .IN_WIDTH(3), .OUT_WIDTH(9), .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(1), .DEBOUNCE_SAMPLES(1), .EDGE_MODE(0),
      .OUT_RESET(9'h000)
   ) u_dut_b (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .avs_address(b_addr), .avs_read(b_rd), .avs_write(b_wr),
      .avs_writedata(b_wd), .avs_readdata(b_rdata),
      .pio_in_export(b_in), .pio_out_export(b_out), .irq(b_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic bus_wr(input int dut, input logic [2:0] addr, input logic [31:0] data);
      @(negedge clk);
      if (dut == 0) begin
         a_addr = addr; a_wd = data; a_wr = 1'b1;
      end else begin
         b_addr = addr; b_wd = data; b_wr = 1'b1;
      end
      @(negedge clk);
      a_wr = 1'b0;
      b_wr = 1'b0;
   endtask

   task automatic bus_rd(input int dut, input logic [2:0] addr, output logic [31:0] data);
      @(negedge clk);
      if (dut == 0) begin
         a_addr = addr; a_rd = 1'b1;
      end else begin
         b_addr = addr; b_rd = 1'b1;
      end
      @(negedge clk);
      a_rd = 1'b0;
      b_rd = 1'b0;
      data = (dut == 0) ? a_rdata : b_rdata;
   endtask

   // Poll DATA of instance A until bit 0 equals want, bounded.
   task automatic wait_a_data(input logic want, output logic ok);
      logic [31:0] rd;
      ok = 1'b0;
      for (int k = 0; k < 25 && !ok; k++) begin
         bus_rd(0, 3'd0, rd);
         if (rd[0] == want) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      do_reset();
      total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want %h", a_rdata, 32'h0); end
      total++; if (a_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want %b", a_irq, 1'b0); end
      total++; if (a_out !== 18'h000A5) begin bad++; $display("FAIL reset_out_a: got %h want %h", a_out, 18'h000A5); end
      total++; if (b_out !== 9'h000) begin bad++; $display("FAIL reset_out_b: got %h want %h", b_out, 9'h000); end
      bus_rd(0, 3'd2, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_mask: got %h want %h", rd, 32'h0); end
      bus_rd(0, 3'd3, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_edge: got %h want %h", rd, 32'h0); end
   endtask

   task automatic test_debounce_irq();
      logic [31:0] rd;
      logic        ok;
      do_reset();
      bus_wr(0, 3'd2, 32'h1);
      a_in[0] = 1'b1;
      bus_rd(0, 3'd0, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL deb_early: got %h want %h", rd, 32'h0); end
      wait_a_data(1'b1, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL deb_rise: got %b want %b", ok, 1'b1); end
      bus_rd(0, 3'd3, rd);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL edge_set: got %h want %h", rd, 32'h1); end
      total++; if (a_irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want %b", a_irq, 1'b1); end
      bus_wr(0, 3'd3, 32'h1);
      total++; if (a_irq !== 1'b1) begin bad++; $display("FAIL irq_hold1: got %b want %b", a_irq, 1'b1); end
      @(negedge clk);
      total++; if (a_irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want %b", a_irq, 1'b0); end
      bus_rd(0, 3'd3, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL edge_clear: got %h want %h", rd, 32'h0); end
   endtask

   task automatic test_bounce();
      logic [31:0] rd;
      logic        seen;
      a_in = '0;
      do_reset();
      bus_wr(0, 3'd2, 32'h1);
      seen = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (t % 5 == 0) a_in[0] = ~a_in[0];
         if (a_irq) seen = 1'b1;
      end
      a_in[0] = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (a_irq) seen = 1'b1;
      end
      bus_rd(0, 3'd0, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL bounce_data: got %h want %h", rd, 32'h0); end
      bus_rd(0, 3'd3, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL bounce_edge: got %h want %h", rd, 32'h0); end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_irq: got %b want %b", seen, 1'b0); end
   endtask

   task automatic test_out_setclr();
      logic [31:0] rd;
      bus_wr(0, 3'd1, 32'h0000_00F0);
      bus_wr(0, 3'd4, 32'h0000_0003);
      bus_wr(0, 3'd5, 32'h0000_0010);
      total++; if (a_out !== 18'h000E3) begin bad++; $display("FAIL out_pins: got %h want %h", a_out, 18'h000E3); end
      bus_rd(0, 3'd1, rd);
      total++; if (rd !== 32'h0000_00E3) begin bad++; $display("FAIL out_read: got %h want %h", rd, 32'h0000_00E3); end
      // readdata must hold across a following write without a read
      bus_wr(0, 3'd4, 32'h0000_0100);
      total++; if (a_rdata !== 32'h0000_00E3) begin bad++; $display("FAIL rdata_hold: got %h want %h", a_rdata, 32'h0000_00E3); end
      bus_rd(0, 3'd4, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL outset_read: got %h want %h", rd, 32'h0); end
      bus_rd(0, 3'd5, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL outclr_read: got %h want %h", rd, 32'h0); end
      bus_rd(0, 3'd6, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rsvd_read: got %h want %h", rd, 32'h0); end
      // simultaneous read and write of OUT returns the old value
      @(negedge clk);
      a_addr = 3'd1; a_wd = 32'h0000_0055; a_rd = 1'b1; a_wr = 1'b1;
      @(negedge clk);
      a_rd = 1'b0; a_wr = 1'b0;
      total++; if (a_rdata !== 32'h0000_01E3) begin bad++; $display("FAIL rw_old: got %h want %h", a_rdata, 32'h0000_01E3); end
      bus_rd(0, 3'd1, rd);
      total++; if (rd !== 32'h0000_0055) begin bad++; $display("FAIL rw_new: got %h want %h", rd, 32'h0000_0055); end
   endtask

   task automatic test_set_wins();
      logic [31:0] rd;
      b_in = '0;
      do_reset();
      bus_wr(1, 3'd2, 32'h1);
      @(negedge clk);
      b_in[0] = 1'b1;
      // sync stage 1, sync stage 2, debounced: edge captures on the 4th edge
      repeat (3) @(negedge clk);
      b_addr = 3'd3; b_wd = 32'h1; b_wr = 1'b1;
      @(negedge clk);
      b_wr = 1'b0;
      @(negedge clk);
      total++; if (b_irq !== 1'b1) begin bad++; $display("FAIL setwin_irq: got %b want %b", b_irq, 1'b1); end
      bus_rd(1, 3'd3, rd);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL setwin_edge: got %h want %h", rd, 32'h1); end
      bus_wr(1, 3'd3, 32'h1);
      @(negedge clk);
      total++; if (b_irq !== 1'b0) begin bad++; $display("FAIL b_irq_clear: got %b want %b", b_irq, 1'b0); end
      bus_rd(1, 3'd0, rd);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL b_data: got %h want %h", rd, 32'h1); end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      logic        ok;
      a_in = '0;
      do_reset();
      bus_wr(0, 3'd2, 32'h1);
      bus_wr(0, 3'd1, 32'h5);
      a_in[0] = 1'b1;
      wait_a_data(1'b1, ok);
      repeat (3) @(negedge clk);
      total++; if (a_irq !== 1'b1) begin bad++; $display("FAIL pre_rst_irq: got %b want %b", a_irq, 1'b1); end
      bus_rd(0, 3'd1, rd);
      a_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      a_addr = 3'd0; a_rd = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL arst_rdata: got %h want %h", a_rdata, 32'h0); end
      total++; if (a_irq !== 1'b0) begin bad++; $display("FAIL arst_irq: got %b want %b", a_irq, 1'b0); end
      total++; if (a_out !== 18'h000A5) begin bad++; $display("FAIL arst_out: got %h want %h", a_out, 18'h000A5); end
      @(negedge clk);
      a_rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      bus_rd(0, 3'd0, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_rst_data: got %h want %h", rd, 32'h0); end
      bus_rd(0, 3'd3, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_rst_edge: got %h want %h", rd, 32'h0); end
      a_in[0] = 1'b1;
      wait_a_data(1'b1, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL post_rst_track: got %b want %b", ok, 1'b1); end
   endtask

   task automatic test_narrow();
      logic [31:0] rd;
      bus_wr(1, 3'd1, 32'hFFFF_FFFF);
      bus_wr(1, 3'd2, 32'hFFFF_FFFF);
      bus_rd(1, 3'd1, rd);
      total++; if (rd !== 32'h0000_01FF) begin bad++; $display("FAIL narrow_out: got %h want %h", rd, 32'h0000_01FF); end
      bus_rd(1, 3'd2, rd);
      total++; if (rd !== 32'h0000_0007) begin bad++; $display("FAIL narrow_mask: got %h want %h", rd, 32'h0000_0007); end
      total++; if (b_out !== 9'h1FF) begin bad++; $display("FAIL narrow_pins: got %h want %h", b_out, 9'h1FF); end
      bus_wr(1, 3'd5, 32'h0000_0F0F);
      bus_rd(1, 3'd1, rd);
      total++; if (rd !== 32'h0000_00F0) begin bad++; $display("FAIL narrow_clr: got %h want %h", rd, 32'h0000_00F0); end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst_n  = 1'b0;
      a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wd = '0; a_in = '0;
      b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wd = '0; b_in = '0;
      test_reset();
      test_debounce_irq();
      test_bounce();
      test_out_setclr();
      test_set_wins();
      test_async_reset();
      test_narrow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
